// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised chain of STAGES pipe stage registers between
// fetch and execute/memory/writeback. Each stage carries a valid flag and an
// instruction word. Supports per-stage hold with upstream back-pressure,
// bubble insertion below a held stage, a global flush and a retire counter.
//
// Build option: define PIPE_CLEAR_BUBBLE_EN to make every bubble insertion
// (fetch stall, below-hold bubble, flush) write instruction 0. Without it a
// bubble clears only the valid flag and the instruction register keeps its
// old contents, so consumers must qualify the instruction with stageActive.
module pipe_stage_chain #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stepPipe,
    input  logic                         pipeStall,
    input  logic [DATA_WIDTH-1:0]        currentInstruction,
    input  logic                         flush,
    input  logic [STAGES-1:0]            stageHold,
    output logic                         inputReady,
    output logic [STAGES-1:0]            stageActive,
    output logic [STAGES*DATA_WIDTH-1:0] stageInstruction,
    output logic                         retireValid,
    output logic [COUNT_WIDTH-1:0]       retireCount
);

`ifdef PIPE_CLEAR_BUBBLE_EN
    localparam bit BUBBLE_CLEAR = 1'b1;
`else
    localparam bit BUBBLE_CLEAR = 1'b0;
`endif

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic [STAGES-1:0]     stage_valid;
    logic [DATA_WIDTH-1:0] stage_data [STAGES];
    logic [STAGES-1:0]     valid_next;
    logic [DATA_WIDTH-1:0] data_next  [STAGES];
    logic [STAGES-1:0]     frozen;
    logic [COUNT_WIDTH-1:0] retire_count;
    logic                  retire_now;

    // A stage is frozen when it or any stage downstream of it is held.
    // Each bit is reduced independently so no combinational chain loops back.
    always_comb begin
        frozen = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            frozen[k] = |(stageHold >> k);
        end
    end

    // The last stage retires when it is valid, not held, and the pipe steps
    // without a flush.
    always_comb begin
        retire_now = stepPipe && !flush && stage_valid[STAGES-1]
                     && !stageHold[STAGES-1];
    end

    // Next-state of every stage: flush beats step; frozen stages keep their
    // contents; the stage just below a frozen one receives a bubble.
    always_comb begin
        valid_next = stage_valid;
        for (int unsigned k = 0; k < STAGES; k++) begin
            data_next[k] = stage_data[k];
        end

        if (flush) begin
            valid_next = '0;
            if (BUBBLE_CLEAR) begin
                for (int unsigned k = 0; k < STAGES; k++) begin
                    data_next[k] = '0;
                end
            end
        end else if (stepPipe) begin
            if (!frozen[0]) begin
                valid_next[0] = !pipeStall;
                if (!pipeStall) begin
                    data_next[0] = currentInstruction;
                end else if (BUBBLE_CLEAR) begin
                    data_next[0] = '0;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (!frozen[k]) begin
                    if (frozen[k-1]) begin
                        valid_next[k] = 1'b0;
                        if (BUBBLE_CLEAR) begin
                            data_next[k] = '0;
                        end
                    end else begin
                        valid_next[k] = stage_valid[k-1];
                        data_next[k]  = stage_data[k-1];
                    end
                end
            end
        end
    end

    // Stage registers and retire counter; reset wins over flush and step.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid  <= '0;
            retire_count <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            stage_valid <= valid_next;
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage_data[k] <= data_next[k];
            end
            if (retire_now) begin
                retire_count <= retire_count + COUNT_ONE;
            end
        end
    end

    // Flatten the per-stage instruction words onto the output bus.
    always_comb begin
        stageInstruction = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stageInstruction[k*DATA_WIDTH +: DATA_WIDTH] = stage_data[k];
        end
    end

    // Drive the remaining outputs from internal state.
    always_comb begin
        inputReady  = !frozen[0] && !flush;
        stageActive = stage_valid;
        retireValid = retire_now;
        retireCount = retire_count;
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed, table-driven check of pipe_stage_chain with
// STAGES=3, DATA_WIDTH=32, COUNT_WIDTH=4. Expected instruction values are the
// stale-register values; bubble stages map to 0 when PIPE_CLEAR_BUBBLE_EN is set.
module tb_pipe_stage_chain;

    localparam int unsigned STAGES = 3;
    localparam int unsigned DW     = 32;
    localparam int unsigned CW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stepPipe;
    logic              pipeStall;
    logic [DW-1:0]     currentInstruction;
    logic              flush;
    logic [STAGES-1:0] stageHold;
    logic              inputReady;
    logic [STAGES-1:0] stageActive;
    logic [STAGES*DW-1:0] stageInstruction;
    logic              retireValid;
    logic [CW-1:0]     retireCount;

    int checks   = 0;
    int failures = 0;

    pipe_stage_chain #(
        .STAGES(STAGES),
        .DATA_WIDTH(DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stepPipe(stepPipe),
        .pipeStall(pipeStall),
        .currentInstruction(currentInstruction),
        .flush(flush),
        .stageHold(stageHold),
        .inputReady(inputReady),
        .stageActive(stageActive),
        .stageInstruction(stageInstruction),
        .retireValid(retireValid),
        .retireCount(retireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        step;
        logic        stall;
        logic        flush;
        logic [2:0]  hold;
        logic [31:0] ins;
        logic        exp_rv;
        logic        exp_ready;
        logic [2:0]  exp_act;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic sl, input logic fl,
                       input logic [2:0] h, input logic [31:0] ins,
                       input logic rv, input logic rdy, input logic [2:0] act,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [3:0] cnt);
        vec_t v;
        v.rst = r; v.step = st; v.stall = sl; v.flush = fl; v.hold = h; v.ins = ins;
        v.exp_rv = rv; v.exp_ready = rdy; v.exp_act = act;
        v.exp_d0 = d0; v.exp_d1 = d1; v.exp_d2 = d2; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, got, want);
        end
    endtask

    function automatic logic [31:0] bub(input logic [31:0] stale);
`ifdef PIPE_CLEAR_BUBBLE_EN
        return 32'h0;
`else
        return stale;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic active, input logic [31:0] stale);
        return active ? stale : bub(stale);
    endfunction

    task automatic drive(input logic r, input logic st, input logic sl, input logic fl,
                         input logic [2:0] h, input logic [31:0] ins);
        rst = r; stepPipe = st; pipeStall = sl; flush = fl;
        stageHold = h; currentInstruction = ins;
    endtask

    initial begin
        logic [STAGES*DW-1:0] si;
        vec_t v;

        //   rst st sl fl hold  ins           rv rdy act    d0            d1            d2            cnt
        // stream 0x11..0x44, then drain with fetch stalls
        add(0, 1, 0, 0, 3'b000, 32'h11,        0, 1, 3'b001, 32'h11,       32'h0,        32'h0,        4'd0);
        add(0, 1, 0, 0, 3'b000, 32'h22,        0, 1, 3'b011, 32'h22,       32'h11,       32'h0,        4'd0);
        add(0, 1, 0, 0, 3'b000, 32'h33,        0, 1, 3'b111, 32'h33,       32'h22,       32'h11,       4'd0);
        add(0, 1, 0, 0, 3'b000, 32'h44,        1, 1, 3'b111, 32'h44,       32'h33,       32'h22,       4'd1);
        add(0, 1, 1, 0, 3'b000, 32'h55,        1, 1, 3'b110, 32'h44,       32'h44,       32'h33,       4'd2);
        add(0, 1, 1, 0, 3'b000, 32'h55,        1, 1, 3'b100, 32'h44,       32'h44,       32'h44,       4'd3);
        add(0, 1, 1, 0, 3'b000, 32'h55,        1, 1, 3'b000, 32'h44,       32'h44,       32'h44,       4'd4);
        // fill, hold stage 1 for two steps, resume
        add(0, 1, 0, 0, 3'b000, 32'hA1,        0, 1, 3'b001, 32'hA1,       32'h44,       32'h44,       4'd4);
        add(0, 1, 0, 0, 3'b000, 32'hA2,        0, 1, 3'b011, 32'hA2,       32'hA1,       32'h44,       4'd4);
        add(0, 1, 0, 0, 3'b000, 32'hA3,        0, 1, 3'b111, 32'hA3,       32'hA2,       32'hA1,       4'd4);
        add(0, 1, 0, 0, 3'b010, 32'hA4,        1, 0, 3'b011, 32'hA3,       32'hA2,       32'hA1,       4'd5);
        add(0, 1, 0, 0, 3'b010, 32'hA4,        0, 0, 3'b011, 32'hA3,       32'hA2,       32'hA1,       4'd5);
        add(0, 1, 0, 0, 3'b000, 32'hA4,        0, 1, 3'b111, 32'hA4,       32'hA3,       32'hA2,       4'd5);
        add(0, 1, 0, 0, 3'b000, 32'hA5,        1, 1, 3'b111, 32'hA5,       32'hA4,       32'hA3,       4'd6);
        // one fetch bubble mid-stream
        add(0, 1, 1, 0, 3'b000, 32'hB0,        1, 1, 3'b110, 32'hA5,       32'hA5,       32'hA4,       4'd7);
        add(0, 1, 0, 0, 3'b000, 32'hA6,        1, 1, 3'b101, 32'hA6,       32'hA5,       32'hA5,       4'd8);
        add(0, 1, 0, 0, 3'b000, 32'hA7,        1, 1, 3'b011, 32'hA7,       32'hA6,       32'hA5,       4'd9);
        add(0, 1, 0, 0, 3'b000, 32'hA8,        0, 1, 3'b111, 32'hA8,       32'hA7,       32'hA6,       4'd9);
        // flush with step and last-stage hold
        add(0, 1, 0, 1, 3'b100, 32'hA9,        0, 0, 3'b000, 32'hA8,       32'hA7,       32'hA6,       4'd9);
        // no step: nothing moves
        add(0, 0, 0, 0, 3'b000, 32'hC1,        0, 1, 3'b000, 32'hA8,       32'hA7,       32'hA6,       4'd9);
        add(0, 1, 0, 0, 3'b000, 32'hC1,        0, 1, 3'b001, 32'hC1,       32'hA8,       32'hA7,       4'd9);
        add(0, 1, 0, 0, 3'b000, 32'hC2,        0, 1, 3'b011, 32'hC2,       32'hC1,       32'hA8,       4'd9);
        add(0, 0, 0, 0, 3'b000, 32'hC3,        0, 1, 3'b011, 32'hC2,       32'hC1,       32'hA8,       4'd9);
        // hold on an inactive last stage freezes everything; stall ignored
        add(0, 1, 1, 0, 3'b100, 32'hC3,        0, 0, 3'b011, 32'hC2,       32'hC1,       32'hA8,       4'd9);
        add(0, 1, 0, 0, 3'b000, 32'hC3,        0, 1, 3'b111, 32'hC3,       32'hC2,       32'hC1,       4'd9);
        add(0, 1, 0, 0, 3'b100, 32'hC4,        0, 0, 3'b111, 32'hC3,       32'hC2,       32'hC1,       4'd9);
        // reset mid-stream with step
        add(1, 1, 0, 0, 3'b000, 32'hC4,        1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        4'd0);

        // initial reset
        drive(1, 0, 0, 0, 3'b000, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 3'b000, 32'h0);
        si = stageInstruction;
        chk("reset_active", -1, 32'(stageActive), 32'h0);
        chk("reset_count",  -1, 32'(retireCount), 32'h0);
        for (int k = 0; k < int'(STAGES); k++) begin
            chk("reset_instr", k, si[k*DW +: DW], 32'h0);
        end
        #3;
        chk("reset_ready", -1, 32'(inputReady), 32'h1);
        chk("reset_rv",    -1, 32'(retireValid), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.step, v.stall, v.flush, v.hold, v.ins);
            #3;
            chk("retireValid", i, 32'(retireValid), 32'(v.exp_rv));
            chk("inputReady",  i, 32'(inputReady),  32'(v.exp_ready));
            @(posedge clk);
            #1;
            si = stageInstruction;
            chk("stageActive", i, 32'(stageActive), 32'(v.exp_act));
            chk("retireCount", i, 32'(retireCount), 32'(v.exp_cnt));
            chk("instr0", i, si[0*DW +: DW], exp_data(v.exp_act[0], v.exp_d0));
            chk("instr1", i, si[1*DW +: DW], exp_data(v.exp_act[1], v.exp_d1));
            chk("instr2", i, si[2*DW +: DW], exp_data(v.exp_act[2], v.exp_d2));
        end

        // counter wrap: 18 steps retire 15, two more wrap 16 -> 0 -> 1
        for (int i = 0; i < 18; i++) begin
            drive(0, 1, 0, 0, 3'b000, 32'hD00 + 32'(i));
            @(posedge clk);
            #1;
        end
        chk("count_pre_wrap", -1, 32'(retireCount), 32'd15);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 3'b000, 32'hE00 + 32'(i));
            #3;
            chk("wrap_rv", i, 32'(retireValid), 32'h1);
            @(posedge clk);
            #1;
        end
        chk("count_wrapped", -1, 32'(retireCount), 32'd1);
        si = stageInstruction;
        chk("wrap_instr2", -1, si[2*DW +: DW], 32'hD11);

        drive(0, 0, 0, 0, 3'b000, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the single core pipe stage.
- Implements a chain of STAGES pipe stage registers, each holding a valid flag and an instruction word.
- Adds per-stage hold with upstream back-pressure, bubble insertion below a held stage, a global flush, and a retired-instruction counter.
- Sits between fetch and the execute/memory/writeback stages of the core; each stage's active flag gates that stage's logic.

Parameters:
- STAGES, 3, number of pipe stages (≥1); stage 0 is nearest fetch, stage STAGES-1 retires.
- DATA_WIDTH, 32, width of the instruction word carried per stage.
- COUNT_WIDTH, 32, width of the retire counter.

Ports:
- clk  input  1  core clock
- rst  input  1  reset: synchronous, active-high, sampled on the rising edge of clk
- stepPipe  input  1  advance strobe; no state changes when low except flush and reset
- pipeStall  input  1  incoming slot is a bubble (no valid instruction from fetch)
- currentInstruction  input  DATA_WIDTH  instruction presented to stage 0
- flush  input  1  invalidate all stages
- stageHold  input  STAGES  bit k: stage k cannot complete this step
- inputReady  output  1  stage 0 will take currentInstruction on stepPipe
- stageActive  output  STAGES  bit k: stage k holds a valid instruction
- stageInstruction  output  STAGES*DATA_WIDTH  stage k in bits [k*DATA_WIDTH +: DATA_WIDTH]
- retireValid  output  1  combinational: last stage retires this step
- retireCount  output  COUNT_WIDTH  registered count of retired instructions

Behaviour:
- Reset:
  - stageActive = 0 and all stageInstruction = 0.
  - retireCount = 0.
  - rst overrides flush and stepPipe.
- frozen[k] = OR of stageHold[STAGES-1:k], combinational.
  - inputReady = !frozen[0] && !flush.
- Flush, when flush=1 and rst=0, regardless of stepPipe:
  - All stageActive clear next cycle.
  - Instructions follow the bubble rule below.
  - retireValid = 0 and the counter does not increment.
  - Flush wins over hold and step.
- Step, when stepPipe=1 and flush=0, for each stage k:
  - If frozen[k]: stage k keeps its valid flag and instruction.
  - Else if k=0: stageActive[0] <= !pipeStall; instruction <= currentInstruction when !pipeStall, else bubble.
  - Else if frozen[k-1] (k-1 held, k free): stage k becomes a bubble (inactive).
  - Else: stage k <= stage k-1 (valid flag and instruction).
- Latency: an instruction accepted with no holds is visible in stage k exactly k+1 steps later, i.e. stageActive[0] goes high one clk after the accepting step.
- retireValid = stepPipe && !flush && stageActive[STAGES-1] && !stageHold[STAGES-1].
  - retireCount += 1 on the same edge.
  - Wraps modulo 2^COUNT_WIDTH.
- Simultaneous events:
  - A hold on an inactive stage still freezes upstream stages.
  - pipeStall=1 with frozen[0] is ignored, since no load occurs.
- STAGES=1: chain degenerates to one stage with hold; the bubble-below-hold rule does not apply.
- stepPipe=0: registers hold; retireValid=0.

Optional Feature:
- Macro: PIPE_CLEAR_BUBBLE_EN.
- Defined: every bubble insertion (pipeStall load, below-hold bubble, flush) writes instruction 0.
- Undefined: bubbles clear only the valid flag and the instruction register keeps its previous value (smaller area). Consumers must qualify the instruction with stageActive.
- Reset clears instructions to 0 in both builds.

Test Plan:
- Reset, then stream 0x11,0x22,0x33,0x44 with stepPipe=1 every cycle, STAGES=3:
  - 0x11 appears in stage 2 on the 3rd edge.
  - retireValid pulses 4 times.
  - retireCount=4.
- Pipe full, hold stageHold[1] for 2 steps:
  - Stages 0–1 unchanged and inputReady=0.
  - Stage 2 retires, then shows a bubble (inactive; instruction 0 with PIPE_CLEAR_BUBBLE_EN).
  - Flow resumes with no lost or duplicated instruction.
- pipeStall=1 on one step mid-stream:
  - One bubble propagates through all stages.
  - retireCount skips exactly one.
- Full pipe, assert flush together with stepPipe and stageHold[2]=1:
  - Next cycle stageActive=0.
  - retireCount unchanged.
  - retireValid=0 during the flush cycle.
- Assert rst mid-stream with stepPipe=1:
  - All outputs are at reset values next cycle.
- Preload retireCount near wrap (COUNT_WIDTH=4, 15 retirements), then retire 2 more:
  - retireCount=1.
